// File: rtl/fwd_scoreboard_u.sv
// ID-stage operand forwarding and hazard unit: picks the nearest valid producer
// per source port and tracks pending long-latency destinations in a scoreboard.
module fwd_scoreboard_u #(
   parameter  int NRS     = 2,
   parameter  int NFWD    = 3,
   parameter  int MAX_OUT = 4,
   parameter  int CNTW    = 16,
   localparam int SELW    = $clog2(NFWD + 2),
   localparam int OUTW    = $clog2(MAX_OUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [NRS*5-1:0]     rs,
   input  logic [NFWD-1:0]      fwd_wr_reg_n,
   input  logic [NFWD*5-1:0]    fwd_rd,
   input  logic [NFWD-1:0]      fwd_avail,
   input  logic                 ll_issue,
   input  logic [4:0]           ll_rd,
   input  logic                 ll_done,
   input  logic [4:0]           ll_done_rd,
   output logic [NRS*SELW-1:0]  fwd_sel,
   output logic                 stall,
   output logic [OUTW-1:0]      ll_outstanding,
   output logic [CNTW-1:0]      stall_cnt,
   output logic                 sb_err
);

   logic [31:0]     pending_q, pending_d;
   logic [OUTW-1:0] ll_outstanding_q, ll_outstanding_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic            sb_err_q, sb_err_d;

   logic [NRS-1:0]  port_stall;
   logic            ll_full;
   logic            clr_ok;
   logic            set_en;

   // Per port: stage hits take precedence over the completion bus, which in turn
   // takes precedence over the scoreboard; the lowest stage index is the youngest.
   always_comb begin : resolve
      logic [4:0]      r;
      logic            hit;
      logic [SELW-1:0] s;
      logic            st;
      fwd_sel    = '0;
      port_stall = '0;
      for (int k = 0; k < NRS; k++) begin
         r   = rs[5*k +: 5];
         hit = 1'b0;
         s   = '0;
         st  = 1'b0;
         if (r != 5'd0) begin
            for (int i = 0; i < NFWD; i++) begin
               if (!hit && !fwd_wr_reg_n[i] && (fwd_rd[5*i +: 5] == r)) begin
                  hit = 1'b1;
                  if (fwd_avail[i]) s = SELW'(i + 1);
                  else              st = 1'b1;
               end
            end
            if (!hit) begin
               if (ll_done && (ll_done_rd == r)) s = SELW'(NFWD + 1);
               else if (pending_q[r])            st = 1'b1;
            end
         end
         fwd_sel[SELW*k +: SELW] = s;
         port_stall[k]           = st;
      end
   end

   // A completion in the same cycle frees a slot, so a full scoreboard only
   // blocks issue when nothing retires.
   assign ll_full = (ll_outstanding_q == OUTW'(MAX_OUT));
   assign stall   = id_valid && ((|port_stall) || (ll_issue && ll_full && !ll_done));

   // Handshake: an ID instruction is accepted on a rising edge when id_valid=1
   // and stall=0; ll_issue only takes effect on such an accepted cycle, while
   // ll_done is a one-cycle pulse consumed unconditionally on the edge it is high.
   always_comb begin
      clr_ok = ll_done && pending_q[ll_done_rd];
      set_en = ll_issue && id_valid && !stall && (ll_rd != 5'd0);

      pending_d = pending_q;
      if (clr_ok) pending_d[ll_done_rd] = 1'b0;
      if (set_en) pending_d[ll_rd]      = 1'b1;

      ll_outstanding_d = ll_outstanding_q;
      if (set_en && !clr_ok && (ll_outstanding_q != '1))
         ll_outstanding_d = ll_outstanding_q + 1'b1;
      else if (clr_ok && !set_en && (ll_outstanding_q != '0))
         ll_outstanding_d = ll_outstanding_q - 1'b1;

      sb_err_d = sb_err_q | (ll_done && !pending_q[ll_done_rd]);

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q        <= '0;
         ll_outstanding_q <= '0;
         stall_cnt_q      <= '0;
         sb_err_q         <= 1'b0;
      end else begin
         pending_q        <= pending_d;
         ll_outstanding_q <= ll_outstanding_d;
         stall_cnt_q      <= stall_cnt_d;
         sb_err_q         <= sb_err_d;
      end
   end

   assign ll_outstanding = ll_outstanding_q;
   assign stall_cnt      = stall_cnt_q;
   assign sb_err         = sb_err_q;

endmodule

// File: tb/tb_fwd_scoreboard_u.sv
// Bench for fwd_scoreboard_u: directed hazard scenarios, then random traffic,
// compared cycle by cycle against a register-array reference model.
module tb_fwd_scoreboard_u;

   localparam int W = 27;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [9:0]  rs = '0;
   logic [2:0]  fwd_wr_reg_n = 3'b111;
   logic [14:0] fwd_rd = '0;
   logic [2:0]  fwd_avail = '0;
   logic        ll_issue = 1'b0;
   logic [4:0]  ll_rd = '0;
   logic        ll_done = 1'b0;
   logic [4:0]  ll_done_rd = '0;
   logic [5:0]  fwd_sel;
   logic        stall;
   logic [2:0]  ll_outstanding;
   logic [15:0] stall_cnt;
   logic        sb_err;

   fwd_scoreboard_u dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs(rs),
      .fwd_wr_reg_n(fwd_wr_reg_n), .fwd_rd(fwd_rd), .fwd_avail(fwd_avail),
      .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
      .fwd_sel(fwd_sel), .stall(stall), .ll_outstanding(ll_outstanding),
      .stall_cnt(stall_cnt), .sb_err(sb_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // reference model state
   bit [31:0] m_pending;
   int        m_out;
   int        m_cnt;
   bit        m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor, samples mid-cycle
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("fwd_sel",        32'(fwd_sel),        32'(e[26:21]));
         check("stall",          32'(stall),          32'(e[20]));
         check("ll_outstanding", 32'(ll_outstanding), 32'(e[19:17]));
         check("stall_cnt",      32'(stall_cnt),      32'(e[16:1]));
         check("sb_err",         32'(sb_err),         32'(e[0]));
      end
   end

   function automatic void model_comb(output logic [5:0] sel, output logic st);
      bit any = 0;
      sel = '0;
      for (int k = 0; k < 2; k++) begin
         int r = int'(rs[5*k +: 5]);
         int hit = -1;
         int s = 0;
         if (r != 0) begin
            for (int i = 0; i < 3; i++)
               if (hit < 0 && !fwd_wr_reg_n[i] && int'(fwd_rd[5*i +: 5]) == r) hit = i;
            if (hit >= 0) begin
               if (fwd_avail[hit]) s = hit + 1;
               else any = 1;
            end else if (ll_done && int'(ll_done_rd) == r) s = 4;
            else if (m_pending[r]) any = 1;
         end
         sel[3*k +: 3] = 3'(s);
      end
      st = id_valid && (any || (ll_issue && m_out == 4 && !ll_done));
   endfunction

   // driver: called at posedge+1 with inputs set; pushes expectation, advances model
   task automatic step();
      logic [5:0] sel;
      logic       st;
      bit         clr, set;
      if (rst) begin
         m_pending = '0; m_out = 0; m_cnt = 0; m_err = 0;
      end
      model_comb(sel, st);
      exp_q.push_back({sel, st, 3'(m_out), 16'(m_cnt), m_err});
      if (!rst) begin
         clr = ll_done && m_pending[ll_done_rd];
         set = ll_issue && id_valid && !st && ll_rd != 0;
         if (ll_done && !clr) m_err = 1;
         if (clr) m_pending[ll_done_rd] = 0;
         if (set) m_pending[ll_rd] = 1;
         m_out = m_out + int'(set) - int'(clr);
         if (m_out > 7) m_out = 7;
         if (m_out < 0) m_out = 0;
         if (st && m_cnt < 65535) m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b1; rs = '0; fwd_wr_reg_n = 3'b111; fwd_rd = '0; fwd_avail = '0;
      ll_issue = 1'b0; ll_rd = '0; ll_done = 1'b0; ll_done_rd = '0;
   endtask

   task automatic issue(input int rd);
      idle(); ll_issue = 1'b1; ll_rd = 5'(rd); step();
   endtask

   task automatic done(input int rd);
      idle(); ll_done = 1'b1; ll_done_rd = 5'(rd); step();
   endtask

   task automatic random_cycle();
      int start;
      id_valid     = ($urandom_range(0, 3) != 0);
      rs           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_wr_reg_n = 3'($urandom_range(0, 7));
      fwd_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_avail    = 3'($urandom_range(0, 7));
      ll_issue     = ($urandom_range(0, 3) == 0);
      ll_rd        = 5'($urandom_range(0, 7));
      ll_done      = 1'b0;
      ll_done_rd   = '0;
      if (m_pending != 0 && $urandom_range(0, 2) == 0) begin
         start = int'($urandom_range(0, 31));
         for (int j = 0; j < 32; j++)
            if (!ll_done && m_pending[(start + j) % 32]) begin
               ll_done = 1'b1; ll_done_rd = 5'((start + j) % 32);
            end
      end else if ($urandom_range(0, 39) == 0) begin
         ll_done = 1'b1; ll_done_rd = 5'($urandom_range(0, 7));
      end
      step();
   endtask

   initial begin
      m_pending = '0; m_out = 0; m_cnt = 0; m_err = 0;
      // reset state, including id_valid with rs=0
      repeat (2) @(posedge clk);
      #1;
      idle();
      step();
      rst = 1'b0;
      step();

      // T1: EX forwarding, available and not yet available
      idle(); fwd_wr_reg_n = 3'b110; fwd_rd[4:0] = 5'd5; fwd_avail = 3'b001; rs[4:0] = 5'd5;
      step();
      fwd_avail = 3'b000;
      step();

      // T2: nearest stage wins, then MEM once EX stops writing
      idle(); fwd_wr_reg_n = 3'b100; fwd_rd = {5'd0, 5'd7, 5'd7}; fwd_avail = 3'b111; rs[9:5] = 5'd7;
      step();
      fwd_wr_reg_n = 3'b101;
      step();

      // T3: long-latency dependency resolved from the completion bus
      issue(9);
      idle(); rs[4:0] = 5'd9; step(); step();
      ll_done = 1'b1; ll_done_rd = 5'd9; step();
      ll_done = 1'b0; step();

      // T4: scoreboard full, then issue plus completion in one cycle
      for (int r = 1; r <= 4; r++) issue(r);
      issue(5);
      idle(); ll_issue = 1'b1; ll_rd = 5'd5; ll_done = 1'b1; ll_done_rd = 5'd1; step();
      for (int r = 2; r <= 5; r++) done(r);

      // T5: spurious completion sets a sticky error
      done(12);
      idle(); step(); step();

      // T6: asynchronous reset with pending entries and a running stall count
      issue(10); issue(11); issue(13);
      idle(); rs = {5'd11, 5'd10}; step(); step(); step();
      rst = 1'b1;
      #1;
      check("rst_async_cnt", 32'(stall_cnt), 32'd0);
      check("rst_async_out", 32'(ll_outstanding), 32'd0);
      check("rst_async_err", 32'(sb_err), 32'd0);
      check("rst_async_stall", 32'(stall), 32'd0);
      step();
      rst = 1'b0;
      step(); step();

      // random traffic
      for (int n = 0; n < 400; n++) random_cycle();

      idle(); id_valid = 1'b0; step();
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
